// File: rtl/router_mc_core.sv
// router_mc_core: one framed input stream routed into NUM_PORTS output FIFOs,
// with parity check, illegal-address drop and per-port stall-timeout flush.
module router_mc_core #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            pkt_valid,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]            read_enb,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_PORTS-1:0]            vld_out,
    output logic                            busy,
    output logic                            err,
    output logic                            drop
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_LOAD, S_CHECK, S_DROP
    } state_t;

    state_t                r_state;
    logic [PORT_W-1:0]     r_dest;
    logic [DATA_WIDTH-1:0] r_hdr;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_pword;
    logic [DATA_WIDTH-1:0] r_mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW:0]           r_wptr [NUM_PORTS];
    logic [AW:0]           r_rptr [NUM_PORTS];
    logic [CW-1:0]         r_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0]  w_empty;
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_flush;
    logic [NUM_PORTS-1:0]  w_wr_en;
    logic [NUM_PORTS-1:0]  w_addr_sel;
    logic [NUM_PORTS-1:0]  w_dst_sel;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [PORT_W-1:0]     w_addr;
    logic                  w_addr_ok;
    logic                  w_in_empty;
    logic                  w_dst_empty;
    logic                  w_dst_full;
    logic                  w_dst_flush;

    always_comb begin
        w_addr      = data_in[PORT_W-1:0];
        w_addr_ok   = int'(w_addr) < NUM_PORTS;
        w_in_empty  = 1'b0;
        w_dst_empty = 1'b0;
        w_dst_full  = 1'b0;
        w_dst_flush = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_empty[p]    = r_wptr[p] == r_rptr[p];
            w_full[p]     = (r_wptr[p][AW] != r_rptr[p][AW]) &&
                            (r_wptr[p][AW-1:0] == r_rptr[p][AW-1:0]);
            w_flush[p]    = !w_empty[p] && !read_enb[p] &&
                            (r_cnt[p] == CW'(TIMEOUT - 1));
            w_addr_sel[p] = w_addr == PORT_W'(p);
            w_dst_sel[p]  = r_dest == PORT_W'(p);
            if (w_addr_sel[p]) w_in_empty = w_empty[p];
            if (w_dst_sel[p]) begin
                w_dst_empty = w_empty[p];
                w_dst_full  = w_full[p];
                w_dst_flush = w_flush[p];
            end
        end
    end

    // A flush of the destination port wins over any write the FSM would do.
    always_comb begin
        w_wr_en   = '0;
        w_wr_data = data_in;
        case (r_state)
            S_IDLE:
                if (pkt_valid && w_addr_ok && w_in_empty)
                    w_wr_en = w_addr_sel;
            S_WAIT:
                if (!w_dst_flush && w_dst_empty) begin
                    w_wr_data = r_hdr;
                    w_wr_en   = w_dst_sel;
                end
            S_LOAD:
                if (!w_dst_flush && !w_dst_full)
                    w_wr_en = w_dst_sel;
            default: ;
        endcase
    end

    assign vld_out = ~w_empty;
    assign busy    = (r_state == S_WAIT) || (r_state == S_CHECK) ||
                     ((r_state == S_LOAD) && w_dst_full);

    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (w_wr_en[p] && !w_flush[p])
                r_mem[p][r_wptr[p][AW-1:0]] <= w_wr_data;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            data_out <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_flush[p]) begin
                    r_wptr[p] <= '0;
                    r_rptr[p] <= '0;
                    r_cnt[p]  <= '0;
                end else begin
                    if (w_wr_en[p])
                        r_wptr[p] <= r_wptr[p] + (AW+1)'(1);
                    if (read_enb[p] && !w_empty[p]) begin
                        data_out[p*DATA_WIDTH +: DATA_WIDTH] <=
                            r_mem[p][r_rptr[p][AW-1:0]];
                        r_rptr[p] <= r_rptr[p] + (AW+1)'(1);
                    end
                    if (w_empty[p] || read_enb[p])
                        r_cnt[p] <= '0;
                    else
                        r_cnt[p] <= r_cnt[p] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state <= S_IDLE;
            r_dest  <= '0;
            r_hdr   <= '0;
            r_acc   <= '0;
            r_pword <= '0;
            err     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (pkt_valid) begin
                        if (!w_addr_ok) begin
                            drop    <= 1'b1;
                            r_state <= S_DROP;
                        end else if (w_in_empty) begin
                            r_dest  <= w_addr;
                            r_acc   <= data_in;
                            err     <= 1'b0;
                            r_state <= S_LOAD;
                        end else begin
                            r_dest  <= w_addr;
                            r_hdr   <= data_in;
                            r_state <= S_WAIT;
                        end
                    end
                S_WAIT:
                    if (w_dst_flush) begin
                        drop    <= 1'b1;
                        r_state <= S_DROP;
                    end else if (w_dst_empty) begin
                        r_acc   <= r_hdr;
                        err     <= 1'b0;
                        r_state <= S_LOAD;
                    end
                S_LOAD:
                    if (w_dst_flush) begin
                        drop    <= 1'b1;
                        r_state <= S_DROP;
                    end else if (!w_dst_full) begin
                        if (pkt_valid) begin
                            r_acc <= r_acc ^ data_in;
                        end else begin
                            r_pword <= data_in;
                            r_state <= S_CHECK;
                        end
                    end
                S_CHECK: begin
                    err     <= r_acc != r_pword;
                    r_state <= S_IDLE;
                end
                S_DROP:
                    if (!pkt_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_mc_core.sv
// Directed self-checking bench for router_mc_core (8-bit, 3 ports, depth 16).
module tb_router_mc_core;
    logic        clock;
    logic        resetn;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  vld_out;
    logic        busy;
    logic        err;
    logic        drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int drops = 0;
    int h;
    int d0;
    logic [7:0] w4 [21];

    router_mc_core #(
        .DATA_WIDTH(8), .NUM_PORTS(3), .FIFO_DEPTH(16), .TIMEOUT(30)
    ) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
        .vld_out(vld_out), .busy(busy), .err(err), .drop(drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (drop) drops <= drops + 1;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clock);
        pkt_valid = v;
        data_in   = d;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic pop(input int p, input logic [7:0] exp);
        @(negedge clock);
        read_enb[p] = 1'b1;
        chk("pop_vld", 32'(vld_out[p]), 1);
        @(posedge clock);
        #1;
        read_enb[p] = 1'b0;
        chk("pop_data", 32'(data_out[p*8 +: 8]), 32'(exp));
    endtask

    initial begin
        resetn    = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        read_enb  = 3'b000;
        repeat (3) @(negedge clock);
        chk("rst_vld", 32'(vld_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_dout", 32'(data_out), 0);
        resetn = 1'b0;

        // good packet to port 1
        send(1, 8'h05);
        chk("t1_vld", 32'(vld_out), 3'b010);
        send(1, 8'hA3);
        send(0, 8'hA6);
        @(negedge clock);
        chk("t1_chk_busy", 32'(busy), 1);
        @(negedge clock);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_err", 32'(err), 0);
        pop(1, 8'h05);
        pop(1, 8'hA3);
        pop(1, 8'hA6);
        #1 chk("t1_empty", 32'(vld_out), 0);

        // parity error
        send(1, 8'h05);
        send(1, 8'hA3);
        send(0, 8'hA7);
        @(negedge clock);
        chk("t2_err_chk", 32'(err), 0);
        @(negedge clock);
        chk("t2_err_set", 32'(err), 1);
        pop(1, 8'h05);
        pop(1, 8'hA3);
        pop(1, 8'hA7);

        // illegal address
        d0 = drops;
        send(1, 8'h03);
        send(1, 8'h11);
        send(1, 8'h22);
        send(1, 8'h33);
        send(1, 8'h44);
        send(0, 8'h55);
        @(negedge clock);
        @(negedge clock);
        chk("t3_drops", 32'(drops - d0), 1);
        chk("t3_vld", 32'(vld_out), 0);
        chk("t3_err_hold", 32'(err), 1);

        // legal packet to port 2, then left unread until it times out
        send(1, 8'h02);
        h = cyc;
        chk("t5_err_clr", 32'(err), 0);
        chk("t5_vld", 32'(vld_out), 3'b100);
        send(1, 8'h11);
        send(0, 8'h13);
        while (cyc != h + 29) @(negedge clock);
        chk("t5_vld_c30", 32'(vld_out[2]), 1);
        @(negedge clock);
        chk("t5_vld_c31", 32'(vld_out[2]), 0);
        chk("t5_dout_hold", 32'(data_out[23:16]), 0);
        chk("t5_err", 32'(err), 0);
        send(1, 8'h06);
        send(1, 8'h77);
        send(0, 8'h71);
        repeat (20) @(negedge clock);
        chk("t5_vld_again", 32'(vld_out[2]), 1);
        pop(2, 8'h06);
        pop(2, 8'h77);
        pop(2, 8'h71);

        // long packet, FIFO fills, reader frees space
        w4[0]  = 8'h00;
        w4[20] = 8'h00;
        for (int i = 1; i < 20; i++) w4[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 20; i++) w4[20] = w4[20] ^ w4[i];
        for (int i = 0; i < 16; i++) send(1, w4[i]);
        @(negedge clock);
        chk("t4_full_busy", 32'(busy), 1);
        fork
            begin
                for (int i = 16; i < 20; i++) send(1, w4[i]);
                send(0, w4[20]);
            end
            begin
                for (int i = 0; i < 5; i++) pop(0, w4[i]);
            end
        join
        for (int i = 5; i < 21; i++) pop(0, w4[i]);
        #1 chk("t4_empty", 32'(vld_out[0]), 0);
        chk("t4_err", 32'(err), 0);

        // second header waits for port 1 to drain
        send(1, 8'h01);
        send(1, 8'h5A);
        send(0, 8'h5B);
        send(1, 8'h09);
        fork
            begin
                send(1, 8'hC4);
                send(0, 8'hCD);
            end
            begin
                @(negedge clock);
                chk("t6_wait_busy", 32'(busy), 1);
                pop(1, 8'h01);
                chk("t6_wait_busy2", 32'(busy), 1);
                pop(1, 8'h5A);
                pop(1, 8'h5B);
            end
        join
        pop(1, 8'h09);
        pop(1, 8'hC4);
        pop(1, 8'hCD);
        #1 chk("t6_empty", 32'(vld_out), 0);
        chk("t6_err", 32'(err), 0);

        // reset mid-packet
        send(1, 8'h01);
        send(1, 8'h22);
        @(negedge clock);
        pkt_valid = 1'b0;
        resetn    = 1'b1;
        #1;
        chk("t7_rst_vld", 32'(vld_out), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        chk("t7_rst_dout", 32'(data_out), 0);
        @(negedge clock);
        resetn = 1'b0;
        send(1, 8'h01);
        send(1, 8'h33);
        send(0, 8'h32);
        pop(1, 8'h01);
        pop(1, 8'h33);
        pop(1, 8'h32);
        @(negedge clock);
        chk("t7_err", 32'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
